// File: rtl/ysyx_25030085_lsu_pkg.sv
// Shared definitions for the load/store unit: memop encodings, FSM states
// and the size/legality helpers used by both the FSM and the lane aligner.
package ysyx_25030085_lsu_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_D  = 3'b011;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;
  localparam logic [2:0] MEMOP_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  // One bit per byte touched by an access of size 2**sz bytes.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] lo);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return lo[0];
      2'd2:    return |lo[1:0];
      default: return |lo;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [2:0] memop, input logic store,
                                      input logic xlen64);
    return (memop == 3'b111) ||
           (!xlen64 && (memop == MEMOP_D || memop == MEMOP_WU)) ||
           (store && memop[2]);
  endfunction

endpackage

// File: rtl/ysyx_25030085_lsu_if.sv
// EXU-side request/result channel and memory-side request/response bus.
// EXU channel: master = EXU, slave = LSU. Memory bus: master = LSU, slave = memory.
interface ysyx_25030085_lsu_exu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              in_ren;
  logic              in_wen;
  logic [2:0]        in_memop;
  logic [ADDR_W-1:0] in_addr;
  logic [XLEN-1:0]   in_wdata;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_rdata;
  logic              out_misalign;
  logic              out_fault;

  modport master (
    output in_valid, in_ren, in_wen, in_memop, in_addr, in_wdata, out_ready,
    input  in_ready, out_valid, out_rdata, out_misalign, out_fault
  );
  modport slave (
    input  in_valid, in_ren, in_wen, in_memop, in_addr, in_wdata, out_ready,
    output in_ready, out_valid, out_rdata, out_misalign, out_fault
  );
endinterface

interface ysyx_25030085_lsu_mem_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_wen;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [XLEN-1:0]   mem_req_wdata;
  logic [XLEN/8-1:0] mem_req_wstrb;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rsp_rdata;
  logic              mem_rsp_err;

  modport master (
    output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );
  modport slave (
    input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );
endinterface

// File: rtl/ysyx_25030085_lsu_align.sv
// Combinational byte-lane steering: store data/strobe placement and load
// extraction with sign or zero extension to XLEN.
module ysyx_25030085_lsu_align
  import ysyx_25030085_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                  memop_i,
  input  logic [$clog2(XLEN/8)-1:0]   off_i,
  input  logic [XLEN-1:0]             wdata_i,
  input  logic [XLEN-1:0]             rdata_i,
  output logic [XLEN-1:0]             wdata_o,
  output logic [XLEN/8-1:0]           wstrb_o,
  output logic [XLEN-1:0]             rdata_o
);
  localparam int STRB_W = XLEN / 8;

  logic [XLEN-1:0] rsh;
  logic [7:0]      mask;
  logic            msb;
  logic            sgn;

  always_comb begin
    mask    = size_mask(memop_i[1:0]);
    wstrb_o = STRB_W'({8'h00, mask} << off_i);
    wdata_o = wdata_i << {off_i, 3'b000};
    rsh     = rdata_i >> {off_i, 3'b000};
    case (memop_i[1:0])
      2'd0:    msb = rsh[7];
      2'd1:    msb = rsh[15];
      default: msb = rsh[31];
    endcase
    sgn = ~memop_i[2] & msb;
    // Lanes covered by the access pass through; the rest carry the extension.
    rdata_o = '0;
    for (int i = 0; i < STRB_W; i++) begin
      rdata_o[8*i +: 8] = mask[i] ? rsh[8*i +: 8] : {8{sgn}};
    end
  end

endmodule

// File: rtl/ysyx_25030085_lsu.sv
// Load/store unit: accepts one EXU request at a time, screens it for illegal
// or misaligned use, runs a single beat on the memory bus and holds the result.
module ysyx_25030085_lsu
  import ysyx_25030085_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ysyx_25030085_lsu_exu_if.slave   exu,
  ysyx_25030085_lsu_mem_if.master  mem
);
  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  lsu_state_e        state_q;
  logic [2:0]        memop_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              store_q;
  logic [XLEN-1:0]   rdata_q;
  logic              fault_q;
  logic              misalign_q;

  logic              in_store;
  logic              in_illegal;
  logic              in_misal;
  logic [XLEN-1:0]   lane_wdata;
  logic [STRB_W-1:0] lane_wstrb;
  logic [XLEN-1:0]   lane_rdata;

  assign in_store   = exu.in_wen & ~exu.in_ren;
  assign in_illegal = is_illegal(exu.in_memop, in_store, XLEN == 64);
  assign in_misal   = is_misaligned(exu.in_memop[1:0], exu.in_addr[2:0]);

  ysyx_25030085_lsu_align #(.XLEN(XLEN)) u_align (
    .memop_i (memop_q),
    .off_i   (addr_q[OFF_W-1:0]),
    .wdata_i (wdata_q),
    .rdata_i (mem.mem_rsp_rdata),
    .wdata_o (lane_wdata),
    .wstrb_o (lane_wstrb),
    .rdata_o (lane_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      memop_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      store_q    <= 1'b0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (exu.in_valid) begin
          memop_q    <= exu.in_memop;
          addr_q     <= exu.in_addr;
          wdata_q    <= exu.in_wdata;
          store_q    <= in_store;
          rdata_q    <= '0;
          fault_q    <= 1'b0;
          misalign_q <= 1'b0;
          // Screening order fixes flag priority: illegal, then misaligned.
          if (in_illegal) begin
            fault_q <= 1'b1;
            state_q <= ST_DONE;
          end else if (in_misal) begin
            misalign_q <= 1'b1;
            state_q    <= ST_DONE;
          end else if (!exu.in_ren && !exu.in_wen) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_REQ;
          end
        end
        ST_REQ: if (mem.mem_req_ready) state_q <= ST_WAIT;
        ST_WAIT: if (mem.mem_rsp_valid) begin
          if (mem.mem_rsp_err) begin
            fault_q <= 1'b1;
            rdata_q <= '0;
          end else if (!store_q) begin
            rdata_q <= lane_rdata;
          end
          state_q <= ST_DONE;
        end
        ST_DONE: if (exu.out_ready) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign exu.in_ready     = rst_n && (state_q == ST_IDLE);
  assign exu.out_valid    = (state_q == ST_DONE);
  assign exu.out_rdata    = rdata_q;
  assign exu.out_fault    = fault_q;
  assign exu.out_misalign = misalign_q;

  assign mem.mem_req_valid = (state_q == ST_REQ);
  assign mem.mem_req_wen   = store_q;
  assign mem.mem_req_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem.mem_req_wdata = lane_wdata;
  assign mem.mem_req_wstrb = store_q ? lane_wstrb : '0;

endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// Bench for the LSU: a 32-bit and a 64-bit instance share one stimulus port,
// selected per transaction, and are checked against a byte-level memop model.
module tb_ysyx_25030085_lsu;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel;
  logic        in_valid, in_ren, in_wen, out_ready;
  logic [2:0]  in_memop;
  logic [31:0] in_addr;
  logic [63:0] in_wdata, rsp_rdata;
  logic        req_ready, rsp_valid, rsp_err;

  ysyx_25030085_lsu_exu_if #(.XLEN(32), .ADDR_W(32)) e32 ();
  ysyx_25030085_lsu_mem_if #(.XLEN(32), .ADDR_W(32)) m32 ();
  ysyx_25030085_lsu_exu_if #(.XLEN(64), .ADDR_W(32)) e64 ();
  ysyx_25030085_lsu_mem_if #(.XLEN(64), .ADDR_W(32)) m64 ();

  ysyx_25030085_lsu #(.XLEN(32), .ADDR_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .exu(e32), .mem(m32));
  ysyx_25030085_lsu #(.XLEN(64), .ADDR_W(32)) dut64 (.clk(clk), .rst_n(rst_n), .exu(e64), .mem(m64));

  assign e32.in_valid = in_valid & ~sel;
  assign e32.in_ren   = in_ren;
  assign e32.in_wen   = in_wen;
  assign e32.in_memop = in_memop;
  assign e32.in_addr  = in_addr;
  assign e32.in_wdata = in_wdata[31:0];
  assign e32.out_ready = out_ready;
  assign m32.mem_req_ready = req_ready;
  assign m32.mem_rsp_valid = rsp_valid;
  assign m32.mem_rsp_rdata = rsp_rdata[31:0];
  assign m32.mem_rsp_err   = rsp_err;

  assign e64.in_valid = in_valid & sel;
  assign e64.in_ren   = in_ren;
  assign e64.in_wen   = in_wen;
  assign e64.in_memop = in_memop;
  assign e64.in_addr  = in_addr;
  assign e64.in_wdata = in_wdata;
  assign e64.out_ready = out_ready;
  assign m64.mem_req_ready = req_ready;
  assign m64.mem_rsp_valid = rsp_valid;
  assign m64.mem_rsp_rdata = rsp_rdata;
  assign m64.mem_rsp_err   = rsp_err;

  logic        o_in_ready, o_out_valid, o_mis, o_fault, o_req_valid, o_req_wen;
  logic [63:0] o_rdata, o_wdata;
  logic [31:0] o_addr;
  logic [7:0]  o_strb;

  assign o_in_ready  = sel ? e64.in_ready     : e32.in_ready;
  assign o_out_valid = sel ? e64.out_valid    : e32.out_valid;
  assign o_mis       = sel ? e64.out_misalign : e32.out_misalign;
  assign o_fault     = sel ? e64.out_fault    : e32.out_fault;
  assign o_rdata     = sel ? e64.out_rdata    : {32'h0, e32.out_rdata};
  assign o_req_valid = sel ? m64.mem_req_valid : m32.mem_req_valid;
  assign o_req_wen   = sel ? m64.mem_req_wen   : m32.mem_req_wen;
  assign o_addr      = sel ? m64.mem_req_addr  : m32.mem_req_addr;
  assign o_wdata     = sel ? m64.mem_req_wdata : {32'h0, m32.mem_req_wdata};
  assign o_strb      = sel ? m64.mem_req_wstrb : {4'h0, m32.mem_req_wstrb};

  int n_vec  = 0;
  int n_miss = 0;
  logic [63:0] last_rdata, last_wdata;
  logic [31:0] last_addr;
  logic [7:0]  last_strb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain byte arithmetic on the memop rules.
  function automatic logic [63:0] xmask(input bit x64);
    return x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic bit m_illegal(input bit x64, input logic [2:0] op, input bit st);
    return (op == 3'd7) || (!x64 && (op == 3'd3 || op == 3'd6)) || (st && op >= 3'd4);
  endfunction

  function automatic logic [63:0] m_load(input bit x64, input logic [2:0] op,
                                         input logic [31:0] addr, input logic [63:0] beat);
    int bw = x64 ? 8 : 4;
    int off = int'(addr % bw);
    int nb = 1 << op[1:0];
    logic [63:0] b = beat & xmask(x64);
    logic [63:0] v = 64'h0;
    for (int i = 0; i < nb; i++) v |= ((b >> (8 * (off + i))) & 64'hFF) << (8 * i);
    if (!op[2] && nb < 8 && v[8*nb-1]) v |= ~((64'd1 << (8 * nb)) - 64'd1);
    return v & xmask(x64);
  endfunction

  task automatic txn(input string tag, input bit x64, input logic [2:0] op,
                     input bit ren, input bit wen, input logic [31:0] addr,
                     input logic [63:0] wdata, input logic [63:0] beat, input bit err,
                     input int rstall, input int ostall);
    bit st   = wen && !ren;
    bit ill  = m_illegal(x64, op, st);
    int bw   = x64 ? 8 : 4;
    int off  = int'(addr % bw);
    int nb   = 1 << op[1:0];
    bit mis  = (addr % nb) != 0;
    bit noop = !ren && !wen;
    logic [63:0] exp_rd, exp_wd;
    logic [7:0]  exp_strb;
    bit exp_fault, exp_mis;
    exp_strb = st ? 8'(((1 << nb) - 1) << off) : 8'h00;
    exp_wd   = ((wdata & xmask(x64)) << (8 * off)) & xmask(x64);
    sel = x64;
    @(negedge clk);
    chk({tag, ":in_ready_idle"}, o_in_ready, 1);
    in_valid = 1'b1; in_ren = ren; in_wen = wen; in_memop = op;
    in_addr = addr; in_wdata = wdata;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ":in_ready_busy"}, o_in_ready, 0);
    if (ill || mis || noop) begin
      chk({tag, ":no_bus"}, o_req_valid, 0);
      exp_rd = 64'h0; exp_fault = ill; exp_mis = !ill && mis;
    end else begin
      chk({tag, ":req_valid"}, o_req_valid, 1);
      chk({tag, ":req_addr"}, o_addr, addr & ~32'(bw - 1));
      chk({tag, ":req_wen"}, o_req_wen, st);
      chk({tag, ":req_strb"}, o_strb, exp_strb);
      if (st) chk({tag, ":req_wdata"}, o_wdata, exp_wd);
      last_addr = o_addr; last_strb = o_strb; last_wdata = o_wdata;
      for (int i = 0; i < rstall; i++) begin
        @(negedge clk);
        chk({tag, ":req_hold_valid"}, o_req_valid, 1);
        chk({tag, ":req_hold_addr"}, o_addr, addr & ~32'(bw - 1));
        chk({tag, ":req_hold_strb"}, o_strb, exp_strb);
        if (st) chk({tag, ":req_hold_wdata"}, o_wdata, exp_wd);
      end
      req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      chk({tag, ":wait_no_req"}, o_req_valid, 0);
      chk({tag, ":wait_no_out"}, o_out_valid, 0);
      rsp_valid = 1'b1; rsp_rdata = beat; rsp_err = err;
      @(negedge clk);
      rsp_valid = 1'b0; rsp_err = 1'b0;
      exp_fault = err; exp_mis = 1'b0;
      exp_rd = (err || st) ? 64'h0 : m_load(x64, op, addr, beat);
    end
    chk({tag, ":out_valid"}, o_out_valid, 1);
    chk({tag, ":rdata"}, o_rdata, exp_rd);
    chk({tag, ":fault"}, o_fault, exp_fault);
    chk({tag, ":misalign"}, o_mis, exp_mis);
    last_rdata = o_rdata;
    for (int i = 0; i < ostall; i++) begin
      @(negedge clk);
      chk({tag, ":out_hold_valid"}, o_out_valid, 1);
      chk({tag, ":out_hold_rdata"}, o_rdata, exp_rd);
      chk({tag, ":out_hold_in_ready"}, o_in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ":out_released"}, o_out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0;
    in_memop = 3'd0; in_addr = 32'h0; in_wdata = 64'h0; out_ready = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = 64'h0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_in_ready", o_in_ready, 0);
      chk("rst_out_valid", o_out_valid, 0);
      chk("rst_req_valid", o_req_valid, 0);
      chk("rst_rdata", o_rdata, 0);
      chk("rst_flags", {62'h0, o_fault, o_mis}, 0);
      chk("rst_strb", o_strb, 0);
    end
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", o_in_ready, 1);

    txn("lb", 0, 3'b000, 1, 0, 32'h8000_0003, 64'h0, 64'h80FF_1234, 0, 0, 0);
    chk("lb_const", last_rdata, 64'h0000_0000_FFFF_FF80);
    txn("lbu", 0, 3'b100, 1, 0, 32'h8000_0003, 64'h0, 64'h80FF_1234, 0, 0, 0);
    chk("lbu_const", last_rdata, 64'h80);
    txn("sh", 0, 3'b001, 0, 1, 32'h8000_0002, 64'h0000_ABCD, 64'h0, 0, 0, 0);
    chk("sh_addr", last_addr, 32'h8000_0000);
    chk("sh_strb", last_strb, 8'b1100);
    chk("sh_wdata", last_wdata, 64'hABCD_0000);
    txn("lw_mis", 0, 3'b010, 1, 0, 32'h8000_0001, 64'h0, 64'h0, 0, 0, 0);
    txn("ld_x32", 0, 3'b011, 1, 0, 32'h8000_0000, 64'h0, 64'h0, 0, 0, 0);
    txn("lwu64", 1, 3'b110, 1, 0, 32'h8000_0004, 64'h0, 64'hDEAD_BEEF_0123_4567, 0, 0, 0);
    chk("lwu64_const", last_rdata, 64'h0000_0000_DEAD_BEEF);
    txn("lw64", 1, 3'b010, 1, 0, 32'h8000_0004, 64'h0, 64'hDEAD_BEEF_0123_4567, 0, 0, 0);
    chk("lw64_const", last_rdata, 64'hFFFF_FFFF_DEAD_BEEF);
    txn("bp", 0, 3'b010, 1, 0, 32'h8000_0008, 64'h0, 64'h1234_5678, 0, 3, 2);
    txn("sd_bp", 1, 3'b011, 0, 1, 32'h8000_0010, 64'h0102_0304_0506_0708, 64'h0, 0, 3, 2);
    txn("buserr", 0, 3'b010, 1, 0, 32'h8000_0004, 64'h0, 64'hCAFE_F00D, 1, 0, 0);
    chk("buserr_rdata", last_rdata, 64'h0);
    txn("sbu_ill", 0, 3'b100, 0, 1, 32'h8000_0000, 64'h55, 64'h0, 0, 0, 0);
    txn("noop", 0, 3'b010, 0, 0, 32'h8000_0004, 64'h0, 64'h0, 0, 0, 0);
    txn("ren_prio", 1, 3'b001, 1, 1, 32'h8000_0006, 64'hFFFF, 64'h8001_0000_0000_0000, 0, 0, 0);

    // Reset abandons an access sitting in WAIT.
    sel = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_ren = 1'b1; in_wen = 1'b0; in_memop = 3'b010; in_addr = 32'h8000_0000;
    @(negedge clk);
    in_valid = 1'b0; req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk("rstw_in_wait", {62'h0, o_req_valid, o_out_valid}, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstw_in_ready", o_in_ready, 1);
    chk("rstw_out_valid", o_out_valid, 0);
    rsp_valid = 1'b1; rsp_rdata = 64'h1111_2222; rsp_err = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b0; rsp_err = 1'b0;
    chk("stray_in_ready", o_in_ready, 1);
    chk("stray_out_valid", o_out_valid, 0);
    chk("stray_fault", o_fault, 0);
    txn("after_rst", 0, 3'b101, 1, 0, 32'h8000_0002, 64'h0, 64'h9ABC_0000, 0, 1, 1);

    for (int k = 0; k < 200; k++) begin
      logic [1:0] rw;
      rw = 2'($urandom_range(0, 3));
      txn("rand", bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rw[0], rw[1],
          32'h8000_0000 | 32'($urandom_range(0, 255)), {$urandom, $urandom},
          {$urandom, $urandom}, $urandom_range(0, 7) == 0,
          $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
